bsn_stream_unloader: RTL
========================

Name: bsn_stream_unloader

Overview:
- Drain-side companion to the 8-input bitonic index-merge sorter.
- Captures one sorted N-word vector from the sorter's `data_out` bus in a single beat, then streams it out one word per beat over a valid/ready interface.
- Each output word carries its lane position and a last flag, so downstream consumers (memory writer, next MDSA dimension) can take sorted data serially.
- Supports lane-0-first or lane-(N-1)-first read order, selected per vector, so either sort direction yields a chosen output order without re-sorting.

Parameters:
- DATA_WIDTH, 32, width of one data word.
- N_INPUTS, 8, words per vector; power of two, minimum 2.
- INDEX_WIDTH, $clog2(N_INPUTS), width of lane position fields.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  reset, asynchronous assert, active-low: rst=0 resets.
- load_valid  input  1  data_in holds a complete sorted vector.
- load_ready  output  1  block can accept a vector this cycle.
- data_in  input  N_INPUTS*DATA_WIDTH  sorted vector; lane k at bits [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k].
- rev  input  1  sampled on load: 0 emits lane 0 first, 1 emits lane N_INPUTS-1 first.
- abort  input  1  synchronous discard of the vector currently held.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts the word.
- out_data  output  DATA_WIDTH  current word.
- out_pos  output  INDEX_WIDTH  lane number of the current word.
- out_last  output  1  current word is the final word of the vector.
- busy  output  1  a vector is held (state STREAM).

Behaviour:
- Reset values (rst=0, asynchronous): state=IDLE; vector buffer=0; rev_q=0; beat counter=0; load_ready=1; out_valid=0; out_data=0; out_pos=0; out_last=0; busy=0.
- Registers: vector buffer (N_INPUTS*DATA_WIDTH), rev_q, beat counter cnt (INDEX_WIDTH bits, counts 0..N_INPUTS-1).
- Outputs are combinational from registers only; there is no combinational path from out_ready or load_valid to out_valid or out_data.
- Lane mapping: out_pos = rev_q ? (N_INPUTS-1-cnt) : cnt. out_data = buffer lane out_pos. out_last = (cnt == N_INPUTS-1) while in STREAM.
- Handshakes:
  - load fire = load_valid && load_ready.
  - out fire = out_valid && out_ready.
  - out_valid, out_data, out_pos and out_last hold stable while out_valid=1 and out_ready=0.
- IDLE:
  - load_ready=1, out_valid=0.
  - On load fire: buffer<=data_in, rev_q<=rev, cnt<=0, go to STREAM.
- STREAM:
  - out_valid=1, busy=1.
  - On out fire with cnt<N_INPUTS-1: cnt<=cnt+1.
  - On out fire with cnt=N_INPUTS-1 (last beat):
    - if load_valid=1: reload buffer and rev_q, cnt<=0, stay in STREAM (back-to-back, no bubble);
    - otherwise go to IDLE.
  - load_ready = out_ready && out_last in STREAM. It depends combinationally on out_ready; this is the only such path.
- Latency: load fire in cycle t gives the first word valid in cycle t+1. A vector takes N_INPUTS beats with no stall. Sustained throughput is one word per cycle across vectors.
- Counter: the last beat is detected by compare, not by wrap. cnt never exceeds N_INPUTS-1.
- abort:
  - When abort=1, state<=IDLE, cnt<=0, and any load fire and out fire in that cycle are ignored.
  - Held data is discarded; out_valid drops the next cycle.
  - abort has priority over all other events.
- An asynchronous reset mid-vector discards the vector. The first out_valid after reset release requires a new load fire.
- In IDLE, out_ready is ignored. In STREAM, load_valid is ignored except on the last-beat fire.

Decomposition:
- Shared package `bsn_pkg` holds:
  - DATA_WIDTH and N_INPUTS defaults shared with the sorter;
  - INDEX_WIDTH derivation;
  - state encoding constants ST_IDLE=1'b0, ST_STREAM=1'b1.
- One natural sub-module, `bsn_lane_mux`: a combinational N_INPUTS:1 word select driven by out_pos, reusable by the sorter's recovery units.
- Everything else (FSM, counter, buffer) stays in the top level.

Test Plan:
- Reset and basic load: release rst, then load_valid=1 with lanes 0..7 = 10,20,...,80, rev=0, out_ready=1 → beats 1..8 show out_data 10..80, out_pos 0..7, out_last=1 only on 80, then out_valid=0 and load_ready=1.
- Reverse order: same vector with rev=1 → out_data 80,70,...,10, out_pos 7..0, out_last on 10.
- Backpressure: out_ready toggles 1,0,0,1,... → every word appears exactly once; out_data and out_pos are stable during stalls; 8 fires total.
- Back-to-back: keep load_valid=1 with vector B (lanes 100..107) during A's last beat → A's 80 is followed by B's 100 the next cycle, with no bubble.
- Abort mid-stream: assert abort after 3 fires → out_valid=0 the next cycle and load_ready=1; a new load restarts at out_pos 0.
- Async reset mid-stream: drive rst=0 between clock edges after 5 fires → all outputs take reset values immediately; after release, out_valid stays 0 until a new load fire.

Source files
------------

// File: rtl/bsn_stream_unloader_pkg.sv
// bsn_pkg: widths and state encoding shared by the sorter drain path
package bsn_pkg;
  localparam int BSN_DATA_WIDTH = 32;
  localparam int BSN_N_INPUTS = 8;
  localparam int BSN_INDEX_WIDTH = $clog2(BSN_N_INPUTS);
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;
endpackage

// File: rtl/bsn_stream_unloader_lane_mux.sv
// bsn_lane_mux: combinational N_INPUTS:1 word select from a packed lane vector
module bsn_lane_mux #(
  parameter int DATA_WIDTH = 32,
  parameter int N_INPUTS = 8,
  parameter int INDEX_WIDTH = $clog2(N_INPUTS)
) (
  input  logic [N_INPUTS*DATA_WIDTH-1:0] data,
  input  logic [INDEX_WIDTH-1:0]         sel,
  output logic [DATA_WIDTH-1:0]          word
);
  logic [DATA_WIDTH-1:0] lanes [N_INPUTS];
  for (genvar k = 0; k < N_INPUTS; k++) begin : g_lane
    assign lanes[k] = data[k*DATA_WIDTH +: DATA_WIDTH];
  end
  assign word = lanes[sel];
endmodule

// File: rtl/bsn_stream_unloader.sv
// bsn_stream_unloader: captures a sorted vector in one beat and streams it out one word per beat
module bsn_stream_unloader
  import bsn_pkg::*;
#(
  parameter int DATA_WIDTH = BSN_DATA_WIDTH,
  parameter int N_INPUTS = BSN_N_INPUTS,
  parameter int INDEX_WIDTH = $clog2(N_INPUTS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load_valid,
  output logic                           load_ready,
  input  logic [N_INPUTS*DATA_WIDTH-1:0] data_in,
  input  logic                           rev,
  input  logic                           abort,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [INDEX_WIDTH-1:0]         out_pos,
  output logic                           out_last,
  output logic                           busy
);
  localparam logic [INDEX_WIDTH-1:0] LAST = INDEX_WIDTH'(N_INPUTS - 1);
  state_t                         state;
  logic [N_INPUTS*DATA_WIDTH-1:0] vec_q;
  logic                           rev_q;
  logic [INDEX_WIDTH-1:0]         cnt;
  logic                           load_fire;
  logic                           out_fire;
  assign busy       = state == ST_STREAM;
  assign out_valid  = busy;
  assign out_last   = busy && cnt == LAST;
  // Accepting a new vector in STREAM is only possible as the last word leaves.
  assign load_ready = busy ? out_ready && out_last : 1'b1;
  assign load_fire  = load_valid && load_ready;
  assign out_fire   = out_valid && out_ready;
  assign out_pos    = rev_q ? LAST - cnt : cnt;
  bsn_lane_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .N_INPUTS   (N_INPUTS),
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_mux (
    .data(vec_q),
    .sel (out_pos),
    .word(out_data)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      vec_q <= '0;
      rev_q <= 1'b0;
      cnt   <= '0;
    end else if (abort) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (load_fire) begin
      state <= ST_STREAM;
      vec_q <= data_in;
      rev_q <= rev;
      cnt   <= '0;
    end else if (out_fire) begin
      state <= out_last ? ST_IDLE : ST_STREAM;
      cnt   <= out_last ? cnt : cnt + 1'b1;
    end
  end
endmodule
